// File: rtl/quad_step_decoder_if.sv
// Encoder-side bundle of the quadrature step decoder: raw phases in, step pulses and position out.
interface quad_step_decoder_if #(
   parameter int unsigned CNT_W = 3
);
   logic             enc_a;
   logic             enc_b;
   logic             up;
   logic             down;
   logic             err;
   logic             primed;
   logic [CNT_W-1:0] count;

   modport master (
      output enc_a, enc_b,
      input  up, down, err, primed, count
   );

   modport slave (
      input  enc_a, enc_b,
      output up, down, err, primed, count
   );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: synchronizes and debounces A/B, then classifies each filtered
// phase transition as a forward step, reverse step or illegal diagonal jump.
module quad_step_decoder #(
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned CNT_W      = 3
) (
   input logic                clk,
   input logic                rst,
   quad_step_decoder_if.slave bus
);
   localparam int unsigned DCNT_W   = 8;
   localparam int unsigned WARM_W   = 2;
   localparam logic [DCNT_W-1:0] DEB_LAST  = DCNT_W'(DEB_CYCLES - 1);
   localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(2);

   // Phase encoding is {A,B}; forward order is P00 -> P01 -> P11 -> P10.
   typedef enum logic [1:0] {
      P00 = 2'b00,
      P01 = 2'b01,
      P10 = 2'b10,
      P11 = 2'b11
   } phase_t;

   // Bit 1 carries channel A, bit 0 channel B throughout.
   logic [1:0]             sync1_q;
   logic [1:0]             sync2_q;
   logic [1:0][DCNT_W-1:0] dcnt_q, dcnt_d;
   logic [1:0][DCNT_W-1:0] stab_q, stab_d;
   logic [WARM_W-1:0]      warm_q, warm_d;
   logic [1:0]             filt_d;
   phase_t                 state_q, state_d;
   logic                   primed_q, primed_d;
   logic                   up_q, up_d;
   logic                   down_q, down_d;
   logic                   err_q, err_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   warm_done;
   logic                   both_match;

   assign warm_done  = (warm_q == WARM_DONE);
   assign both_match = (sync2_q == logic'(state_q[1]) ? 1'b0 : 1'b0) | (sync2_q == 2'(state_q));

   // Per-channel debounce plus the stability counters that gate priming.
   always_comb begin
      dcnt_d = dcnt_q;
      stab_d = stab_q;
      filt_d = 2'(state_q);
      warm_d = warm_done ? warm_q : warm_q + WARM_W'(1);
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] == state_q[i]) begin
            dcnt_d[i] = '0;
            if (warm_done && (stab_q[i] != DEB_LAST)) begin
               stab_d[i] = stab_q[i] + DCNT_W'(1);
            end
         end else begin
            stab_d[i] = '0;
            if (dcnt_q[i] == DEB_LAST) begin
               filt_d[i] = sync2_q[i];
               dcnt_d[i] = '0;
            end else begin
               dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
            end
         end
      end
   end

   // Stability is only counted once the synchronizer holds post-reset samples.
   always_comb begin
      primed_d = primed_q;
      if (warm_done && both_match && (stab_q[0] == DEB_LAST) && (stab_q[1] == DEB_LAST)) begin
         primed_d = 1'b1;
      end
   end

   // Phase FSM: next state always follows the filter; pulses only once primed.
   always_comb begin
      state_d = phase_t'(filt_d);
      up_d    = 1'b0;
      down_d  = 1'b0;
      err_d   = 1'b0;
      count_d = count_q;
      if (primed_q && (state_d != state_q)) begin
         unique case (state_q)
            P00: begin
               up_d   = (state_d == P01);
               down_d = (state_d == P10);
               err_d  = (state_d == P11);
            end
            P01: begin
               up_d   = (state_d == P11);
               down_d = (state_d == P00);
               err_d  = (state_d == P10);
            end
            P11: begin
               up_d   = (state_d == P10);
               down_d = (state_d == P01);
               err_d  = (state_d == P00);
            end
            P10: begin
               up_d   = (state_d == P00);
               down_d = (state_d == P11);
               err_d  = (state_d == P01);
            end
            default: begin
               err_d = 1'b1;
            end
         endcase
         if (up_d) begin
            count_d = count_q + CNT_W'(1);
         end else if (down_d) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         dcnt_q   <= '0;
         stab_q   <= '0;
         warm_q   <= '0;
         state_q  <= P00;
         primed_q <= 1'b0;
         up_q     <= 1'b0;
         down_q   <= 1'b0;
         err_q    <= 1'b0;
         count_q  <= '0;
      end else begin
         sync1_q  <= {bus.enc_a, bus.enc_b};
         sync2_q  <= sync1_q;
         dcnt_q   <= dcnt_d;
         stab_q   <= stab_d;
         warm_q   <= warm_d;
         state_q  <= state_d;
         primed_q <= primed_d;
         up_q     <= up_d;
         down_q   <= down_d;
         err_q    <= err_d;
         count_q  <= count_d;
      end
   end

   assign bus.up     = up_q;
   assign bus.down   = down_q;
   assign bus.err    = err_q;
   assign bus.primed = primed_q;
   assign bus.count  = count_q;
endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: expected pulses are queued when phases are driven.
module tb_quad_step_decoder;
   localparam int DEB = 4;
   localparam int CW  = 3;
   localparam int LAT = DEB + 2;

   typedef struct {
      int            kind;   // 1 up, 2 down, 3 err
      int            cyc;
      logic [CW-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic [1:0]    m_ab;
   logic [CW-1:0] m_cnt;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   quad_step_decoder_if #(.CNT_W(CW)) bus ();

   quad_step_decoder #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic int gidx(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // Pulse monitor: every pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      int   kind;
      int   nhot;
      exp_t e;
      nhot = int'(bus.up) + int'(bus.down) + int'(bus.err);
      kind = bus.up ? 1 : (bus.down ? 2 : (bus.err ? 3 : 0));
      if (nhot != 0) begin
         checks++;
         if (nhot != 1) begin
            errors++;
            $display("FAIL pulse_exclusive: cycle %0d up=%b down=%b err=%b, required one-hot",
                     cyc, bus.up, bus.down, bus.err);
         end
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL pulse_unexpected: kind %0d at cycle %0d, required no pulse", kind, cyc);
         end else begin
            e = sb.pop_front();
            if (kind !== e.kind || cyc != e.cyc || bus.count !== e.cnt) begin
               errors++;
               $display("FAIL pulse_match: got kind %0d cyc %0d count %0d, required kind %0d cyc %0d count %0d",
                        kind, cyc, bus.count, e.kind, e.cyc, e.cnt);
            end
         end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
         checks++;
         errors++;
         $display("FAIL pulse_missing: kind %0d expected at cycle %0d, none by cycle %0d",
                  sb[0].kind, sb[0].cyc, cyc);
         void'(sb.pop_front());
      end
   end

   // Drive a new phase at a negedge, queue the expected outcome, then dwell.
   task automatic step(input logic [1:0] ab, input int hold);
      int kind;
      if (ab == m_ab)                  kind = 0;
      else if ((ab ^ m_ab) == 2'b11)   kind = 3;
      else if (gidx(ab) == (gidx(m_ab) + 1) % 4) kind = 1;
      else                             kind = 2;
      if (kind == 1) m_cnt = m_cnt + CW'(1);
      if (kind == 2) m_cnt = m_cnt - CW'(1);
      if (kind != 0) sb.push_back('{kind, cyc + LAT, m_cnt});
      m_ab      = ab;
      bus.enc_a = ab[1];
      bus.enc_b = ab[0];
      repeat (hold) @(negedge clk);
   endtask

   task automatic check_count(input string name);
      checks++;
      if (bus.count !== m_cnt) begin
         errors++;
         $display("FAIL %s: count %0d, required %0d", name, bus.count, m_cnt);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() > 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d pulses outstanding, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   // Two reset cycles, then verify cleared outputs and priming latency.
   task automatic do_reset(input string name);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.up !== 1'b0 || bus.down !== 1'b0 || bus.err !== 1'b0 ||
          bus.primed !== 1'b0 || bus.count !== '0) begin
         errors++;
         $display("FAIL %s_cleared: up=%b down=%b err=%b primed=%b count=%0d, required all 0",
                  name, bus.up, bus.down, bus.err, bus.primed, bus.count);
      end
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      m_cnt = '0;
      m_ab  = {bus.enc_a, bus.enc_b};
      repeat (LAT - 1) @(negedge clk);
      checks++;
      if (bus.primed !== 1'b0) begin
         errors++;
         $display("FAIL %s_prime_early: primed %b at %0d cycles, required 0", name, bus.primed, LAT - 1);
      end
      @(negedge clk);
      checks++;
      if (bus.primed !== 1'b1) begin
         errors++;
         $display("FAIL %s_prime: primed %b at %0d cycles, required 1", name, bus.primed, LAT);
      end
      check_count({name, "_count"});
   endtask

   task automatic test_reset();
      bus.enc_a = 1'b0;
      bus.enc_b = 1'b0;
      do_reset("reset");
      repeat (5) @(negedge clk);
   endtask

   task automatic test_forward();
      step(2'b01, 10);
      step(2'b11, 10);
      step(2'b10, 10);
      step(2'b00, 10);
      drain("forward");
      check_count("forward_count");
   endtask

   task automatic test_glitch();
      bus.enc_a = 1'b1;
      repeat (3) @(negedge clk);
      bus.enc_a = 1'b0;
      repeat (12) @(negedge clk);
      check_count("glitch_count");
      step(2'b01, 10);
      step(2'b00, 10);
      drain("glitch");
      check_count("glitch_after");
   endtask

   task automatic test_illegal();
      step(2'b11, 10);
      drain("illegal");
      check_count("illegal_count");
      step(2'b10, 10);
      drain("illegal_next");
      check_count("illegal_next_count");
   endtask

   task automatic test_reset_mid_run();
      checks++;
      if (bus.count !== CW'(5)) begin
         errors++;
         $display("FAIL midrun_start: count %0d, required 5", bus.count);
      end
      step(2'b00, 2);
      do_reset("midrun");
      repeat (10) @(negedge clk);
      check_count("midrun_settled");
   endtask

   task automatic test_reverse_wrap();
      step(2'b10, 10);
      check_count("wrap_count");
      step(2'b11, 10);
      drain("reverse");
      check_count("reverse_count");
   endtask

   task automatic test_back_to_back();
      step(2'b01, DEB + 1);
      step(2'b00, DEB + 1);
      step(2'b10, DEB + 1);
      step(2'b00, DEB + 1);
      step(2'b01, DEB + 1);
      repeat (LAT + 2) @(negedge clk);
      drain("b2b");
      check_count("b2b_count");
   endtask

   initial begin
      rst   = 1'b1;
      m_ab  = 2'b00;
      m_cnt = '0;
      test_reset();
      test_forward();
      test_glitch();
      test_illegal();
      test_reset_mid_run();
      test_reverse_wrap();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end
endmodule
